// File: rtl/gray2bin_sync_gray2bin.sv
// Combinational gray-to-binary converter.
// Each binary bit is the XOR of all gray bits at or above its position.
module gray2bin #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  // Reduction XOR over the upper slice keeps every bit independent of the
  // others, so no combinational chain through bin_out itself is formed.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin_out[gi] = ^gray_in[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray2bin_sync.sv
// Synchronizes a foreign-domain gray count, converts it to binary, and
// reports per-change deltas plus a sticky flag for illegal multi-bit jumps.
module gray2bin_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic             upd,
  output logic [WIDTH-1:0] delta,
  output logic             err
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_param
      $error("gray2bin_sync: SYNC_STAGES must be at least 2");
    end
  endgenerate

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             valid_q, valid_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] bin_s;
  logic [WIDTH-1:0] flip;
  logic             changed;
  logic             multi_flip;

  assign gray_s = sync_q[SYNC_STAGES-1];

  gray2bin #(
    .WIDTH (WIDTH)
  ) u_gray2bin (
    .gray_in (gray_s),
    .bin_out (bin_s)
  );

  // Shift the asynchronous input down the synchronizer chain.
  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flops; only the last stage is ever used by logic.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  // A change is legal only when exactly one bit flips; x & (x-1) is nonzero
  // precisely when more than one bit of x is set.
  assign flip       = gray_s ^ gray_prev_q;
  assign changed    = (flip != '0);
  assign multi_flip = ((flip & (flip - 1'b1)) != '0);

  // Sequencing: let the chain fill, prime the reference, then track changes.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    gray_prev_d = gray_prev_q;
    bin_d       = bin_q;
    delta_d     = delta_q;
    valid_d     = valid_q;
    upd_d       = 1'b0;
    err_d       = err_q;

    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      FILL: begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (fill_cnt_q == CNT_W'(SYNC_STAGES - 1)) begin
          state_d = PRIME;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      PRIME: begin
        gray_prev_d = gray_s;
        bin_d       = bin_s;
        valid_d     = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (changed) begin
          gray_prev_d = gray_s;
          bin_d       = bin_s;
          delta_d     = bin_s - bin_q;
          upd_d       = 1'b1;
          if (multi_flip) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Control and datapath state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= FILL;
      fill_cnt_q  <= '0;
      gray_prev_q <= '0;
      bin_q       <= '0;
      delta_q     <= '0;
      valid_q     <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      gray_prev_q <= gray_prev_d;
      bin_q       <= bin_d;
      delta_q     <= delta_d;
      valid_q     <= valid_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign valid   = valid_q;
  assign upd     = upd_q;
  assign delta   = delta_q;
  assign err     = err_q;

endmodule

// File: tb/tb_gray2bin_sync.sv
// Randomized scoreboard bench for gray2bin_sync (WIDTH=8, SYNC_STAGES=2).
module tb_gray2bin_sync;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] dlt;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] bin_out;
  logic         valid;
  logic         upd;
  logic [W-1:0] delta;
  logic         err;

  int checks = 0;
  int errors = 0;

  exp_t         exp_q[$];
  int           g2b[256];
  logic [W-1:0] model_gray;
  logic [W-1:0] model_bin;
  logic         model_err;

  gray2bin_sync #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .gray_in (gray_in),
    .err_clr (err_clr),
    .bin_out (bin_out),
    .valid   (valid),
    .upd     (upd),
    .delta   (delta),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] bin2gray(input int b);
    int g;
    g = b ^ (b >> 1);
    return W'(g);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every upd pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nrst && upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_upd", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("upd_bin", int'(bin_out), int'(e.bin));
        chk("upd_delta", int'(delta), int'(e.dlt));
        chk("upd_err", int'(err), int'(e.err));
        $display("upd: bin=%0h delta=%0h err=%0b", bin_out, delta, err);
      end
    end
  end

  // Reset with a given input, then verify the FILL/PRIME timing.
  task automatic do_reset(input logic [W-1:0] g);
    @(posedge clk); #1;
    nrst = 1'b0;
    gray_in = g;
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_delta", int'(delta), 0);
    chk("rst_upd", int'(upd), 0);
    chk("rst_err", int'(err), 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk("prime_valid", int'(valid), (e == 3) ? 1 : 0);
      chk("prime_upd", int'(upd), 0);
      chk("prime_err", int'(err), 0);
    end
    chk("prime_bin", int'(bin_out), g2b[int'(g)]);
    model_gray = g;
    model_bin  = W'(g2b[int'(g)]);
    model_err  = 1'b0;
    $display("reset: gray_in=%0h bin_out=%0h valid=%0b", g, bin_out, valid);
  endtask

  // Apply one input step lasting four cycles; optionally pulse err_clr in
  // the cycle the DUT evaluates the new synchronized value.
  task automatic step(input logic [W-1:0] g, input bit clr_same);
    exp_t e;
    logic [W-1:0] nb;
    logic [W-1:0] x;
    nb = W'(g2b[int'(g)]);
    if (clr_same) model_err = 1'b0;
    if (g != model_gray) begin
      x = g ^ model_gray;
      if ($countones(x) > 1) model_err = 1'b1;
      e.bin = nb;
      e.dlt = nb - model_bin;
      e.err = model_err;
      exp_q.push_back(e);
    end
    model_gray = g;
    model_bin  = nb;
    @(posedge clk); #1;
    gray_in = g;
    repeat (2) @(posedge clk);
    #1 err_clr = clr_same;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    model_err = 1'b0;
    @(negedge clk);
    chk("clr_err", int'(err), 0);
  endtask

  initial begin
    logic [W-1:0] g;
    for (int b = 0; b < 256; b++) begin
      g2b[(b ^ (b >> 1)) & 255] = b;
    end
    model_gray = '0;
    model_bin  = '0;
    model_err  = 1'b0;

    do_reset(8'h00);

    // Full counting sweep including the 255 -> 0 wrap.
    for (int i = 1; i <= 256; i++) begin
      step(bin2gray(i % 256), 1'b0);
    end

    // Two-bit jump sets sticky err; stays until cleared.
    step(8'h03, 1'b0);
    step(bin2gray(5), 1'b0);
    @(negedge clk);
    chk("err_sticky", int'(err), 1);
    clear_err();

    // Backward step of one.
    step(bin2gray(4), 1'b0);

    // err_clr coinciding with an illegal jump: set wins.
    step(bin2gray(4) ^ 8'h81, 1'b1);
    @(negedge clk);
    chk("set_wins", int'(err), 1);
    clear_err();

    // Randomized mix of legal single-bit flips and arbitrary jumps.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        g = model_gray ^ W'(1 << $urandom_range(0, W-1));
      end else begin
        g = W'($urandom_range(0, 255));
      end
      step(g, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) clear_err();
    end

    // Reset while a change is still in the synchronizer.
    step(bin2gray(3), 1'b0);
    @(posedge clk); #1;
    gray_in = bin2gray(9);
    @(posedge clk); #1;
    do_reset(bin2gray(9));

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray2bin_sync.md
GRAY2BIN_SYNC -- requirements
Module: gray2bin_sync

Interface
REQ-001 Parameter WIDTH, default 32, bit width of the gray-coded count.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, flip-flop depth of the input synchronizer.
REQ-003 One clock; reset is asynchronous and active-low, on ports clk and nrst.
REQ-004 clk  input  1  single clock; all flops rising-edge.
REQ-005 nrst  input  1  async active-low reset.
REQ-006 gray_in  input  WIDTH  gray-coded count from a foreign domain, treated as asynchronous.
REQ-007 err_clr  input  1  synchronous clear of the sticky error flag.
REQ-008 bin_out  output  WIDTH  registered binary equivalent of the synchronized gray value.
REQ-009 valid  output  1  high once bin_out holds a converted sample after reset.
REQ-010 upd  output  1  one-cycle pulse when bin_out changes value.
REQ-011 delta  output  WIDTH  (new bin_out - previous bin_out) mod 2^WIDTH, qualified by upd.
REQ-012 err  output  1  sticky flag: illegal gray transition (more than one bit flipped between consecutive samples).

Function
REQ-013 gray_in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (gray_s) feeds logic.
REQ-014 Conversion SHALL be gray-to-binary: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] XOR g[i] for i < WIDTH-1.
REQ-015 FSM states: FILL, PRIME, RUN.
REQ-016 FILL: entered on reset; counts SYNC_STAGES cycles; valid, upd, err held 0; then goes to PRIME.
REQ-017 PRIME: one cycle; loads gray_prev <= gray_s and bin_out <= conv(gray_s); sets valid = 1; no upd and no err; goes to RUN.
REQ-018 RUN: each cycle, if gray_s != gray_prev: bin_out <= conv(gray_s), gray_prev <= gray_s, delta <= conv(gray_s) - bin_out, upd = 1 for exactly that cycle.
REQ-019 RUN with gray_s == gray_prev: bin_out, delta and gray_prev hold; upd = 0.
REQ-020 RUN: if popcount(gray_s XOR gray_prev) > 1, set err = 1 in the same cycle as upd; bin_out still updates to the new value.
REQ-021 err SHALL remain set until err_clr = 1; if err_clr and a new illegal transition occur in the same cycle, err = 1 (set wins).
REQ-022 Latency: a stable change on gray_in SHALL be visible on bin_out/upd after SYNC_STAGES+1 rising edges.
REQ-023 Wrap-around: the transition from all-ones binary to 0 is legal (one gray bit flips); delta = 1, no err.
REQ-024 delta SHALL be computed modulo 2^WIDTH; a backward step of one gives delta = all ones.
REQ-025 The FSM SHALL never leave RUN except on reset.

Reset
REQ-026 On nrst = 0, asynchronously: sync chain, gray_prev, bin_out, delta and fill counter = 0; valid = upd = err = 0; state = FILL.
REQ-027 Reset asserted mid-operation SHALL abort any pending update; after release the full FILL/PRIME sequence repeats, with no upd or err from the pre-reset value.

Structure
REQ-028 No shared package; the FSM state enum and fill counter width (clog2 of SYNC_STAGES+1) are local to the module.
REQ-029 One combinational sub-module, gray2bin (parameter WIDTH; ports gray_in, bin_out), instantiated on gray_s; the same codebase instantiation pattern as its bin2gray counterpart.
REQ-030 Sync chain flops SHALL carry the codebase's synchronizer attribute for false-path and placement.

Verification (WIDTH = 8, SYNC_STAGES = 2)
REQ-031 Reset release with gray_in = 8'h00: valid rises on the 3rd edge (after 2 FILL edges and 1 PRIME edge); bin_out = 0; upd = 0 and err = 0 throughout.
REQ-032 Drive gray_in as bin2gray(0..255, 0), one step every 4 cycles: one upd per step; delta = 1 each time, including the wrap 255 -> 0; bin_out tracks the count; err = 0.
REQ-033 Step gray_in 8'h00 -> 8'h03 in one move: upd = 1, bin_out = 8'h02, delta = 8'h02, err = 1; err stays 1 until err_clr is pulsed, then returns to 0.
REQ-034 gray_in = bin2gray(5) -> bin2gray(4): delta = 8'hFF, err = 0.
REQ-035 Assert nrst while a change is still inside the sync chain, then release with gray_in = bin2gray(9): no upd is emitted; after PRIME, bin_out = 9 and valid = 1.
REQ-036 err_clr pulsed in the same cycle as a two-bit jump: err = 1 afterwards.
